// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller: result kinds,
// the "source not read" Tuse value and the select codes of every forwarding mux.
package hazard_fwd_ctrl_pkg;

  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_PC8  = 2'd1;
  localparam logic [1:0] KIND_MEM  = 2'd2;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [2:0] SEL_D_RD1   = 3'd0;
  localparam logic [2:0] SEL_D_PC8_E = 3'd1;
  localparam logic [2:0] SEL_D_AO_M  = 3'd2;
  localparam logic [2:0] SEL_D_PC8_M = 3'd3;
  localparam logic [2:0] SEL_D_WD_W  = 3'd4;

  localparam logic [1:0] SEL_E_RD1   = 2'd0;
  localparam logic [1:0] SEL_E_AO_M  = 2'd1;
  localparam logic [1:0] SEL_E_PC8_M = 2'd2;
  localparam logic [1:0] SEL_E_WD_W  = 2'd3;

  localparam logic [0:0] SEL_M_RD2   = 1'b0;
  localparam logic [0:0] SEL_M_WD_W  = 1'b1;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_pick.sv
// Priority matcher: source index against up to three producer records,
// slot 0 is the youngest. A matching but not-yet-ready producer yields code 0.
module fwd_pick #(
  parameter int REG_W = 5,
  parameter int SEL_W = 3
) (
  input  logic [REG_W-1:0]           src_i,
  input  logic [2:0][REG_W-1:0]      wr_i,
  input  logic [2:0]                 ok_i,
  input  logic [2:0][SEL_W-1:0]      code_i,
  output logic [SEL_W-1:0]           sel_o
);

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    sel_o = '0;
    for (int i = 2; i >= 0; i--) begin
      if (src_i != '0 && wr_i[i] == src_i)
        sel_o = ok_i[i] ? code_i[i] : '0;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Optional stall counter output under `define HAZARD_STALL_CNT_EN.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int TN_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [TN_W-1:0]  tuse_rs_d,
  input  logic [TN_W-1:0]  tuse_rt_d,
  input  logic [REG_W-1:0] wr_d,
  input  logic [TN_W-1:0]  tnew_d,
  input  logic [1:0]       kind_d,
  output logic             stall,
  output logic             flush_e,
  output logic [2:0]       rsd_op,
  output logic [2:0]       rtd_op,
  output logic [1:0]       rse_op,
  output logic [1:0]       rte_op,
  output logic             rtm_op
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] wr;
    logic [TN_W-1:0]  tnew;
    logic [1:0]       kind;
  } rec_t;

  rec_t e_q, e_d, m_q, m_d, w_q, w_d;

  // A source stalls D when a producer in E or M cannot deliver by its use cycle.
  function automatic logic late(input logic [REG_W-1:0] src, input logic [TN_W-1:0] tuse,
                                input rec_t e, input rec_t m);
    return (tuse != TN_W'(TUSE_NONE)) && (src != '0) &&
           ((e.wr == src && e.tnew > tuse) || (m.wr == src && m.tnew > tuse));
  endfunction

  assign stall   = late(rs_d, tuse_rs_d, e_q, m_q) || late(rt_d, tuse_rt_d, e_q, m_q);
  assign flush_e = stall;

  always_comb begin
    e_d = stall ? '0 : '{rs: rs_d, rt: rt_d, wr: wr_d, tnew: tnew_d, kind: kind_d};
    m_d = e_q;
    if (e_q.tnew != '0) m_d.tnew = e_q.tnew - TN_W'(1);
    w_d = m_q;
    w_d.tnew = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // M can forward only once its result exists and is not still in memory.
  logic       m_ok;
  logic [2:0] d_code_m;
  logic [1:0] e_code_m;
  assign m_ok     = (m_q.tnew == '0) && (m_q.kind == KIND_ALU || m_q.kind == KIND_PC8);
  assign d_code_m = (m_q.kind == KIND_PC8) ? SEL_D_PC8_M : SEL_D_AO_M;
  assign e_code_m = (m_q.kind == KIND_PC8) ? SEL_E_PC8_M : SEL_E_AO_M;

  fwd_pick #(.REG_W(REG_W), .SEL_W(3)) u_pick_rsd (
    .src_i(rs_d), .wr_i({w_q.wr, m_q.wr, e_q.wr}),
    .ok_i({1'b1, m_ok, e_q.kind == KIND_PC8}),
    .code_i({SEL_D_WD_W, d_code_m, SEL_D_PC8_E}), .sel_o(rsd_op));

  fwd_pick #(.REG_W(REG_W), .SEL_W(3)) u_pick_rtd (
    .src_i(rt_d), .wr_i({w_q.wr, m_q.wr, e_q.wr}),
    .ok_i({1'b1, m_ok, e_q.kind == KIND_PC8}),
    .code_i({SEL_D_WD_W, d_code_m, SEL_D_PC8_E}), .sel_o(rtd_op));

  fwd_pick #(.REG_W(REG_W), .SEL_W(2)) u_pick_rse (
    .src_i(e_q.rs), .wr_i({REG_W'(0), w_q.wr, m_q.wr}),
    .ok_i({1'b0, 1'b1, m_ok}),
    .code_i({SEL_E_RD1, SEL_E_WD_W, e_code_m}), .sel_o(rse_op));

  fwd_pick #(.REG_W(REG_W), .SEL_W(2)) u_pick_rte (
    .src_i(e_q.rt), .wr_i({REG_W'(0), w_q.wr, m_q.wr}),
    .ok_i({1'b0, 1'b1, m_ok}),
    .code_i({SEL_E_RD1, SEL_E_WD_W, e_code_m}), .sel_o(rte_op));

  fwd_pick #(.REG_W(REG_W), .SEL_W(1)) u_pick_rtm (
    .src_i(m_q.rt), .wr_i({REG_W'(0), REG_W'(0), w_q.wr}),
    .ok_i(3'b001),
    .code_i({SEL_M_RD2, SEL_M_RD2, SEL_M_WD_W}), .sel_o(rtm_op));

  logic unused_fields;
  assign unused_fields = ^{m_q.rs, w_q.rs, w_q.rt, w_q.tnew, w_q.kind};

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d     = (stall && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  assign stall_cnt = cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

endmodule
